// File: rtl/pwm_multi_pkg.sv
// Shared register map constants and bus helpers for the multi-channel PWM slave.
package pwm_multi_pkg;

    localparam int unsigned REG_CTRL   = 0;
    localparam int unsigned REG_POL    = 1;
    localparam int unsigned REG_STATUS = 2;
    localparam int unsigned REG_IRQ_EN = 3;
    localparam int unsigned CH_BASE    = 4;
    localparam int unsigned CH_STRIDE  = 2;

    function automatic int addr_w(input int unsigned num_ch);
        return $clog2(CH_BASE + CH_STRIDE * num_ch);
    endfunction

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] mask;
        mask = '0;
        for (int k = 0; k < 4; k++) begin
            mask[8*k +: 8] = {8{be[k]}};
        end
        return mask;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                          input logic [3:0] be);
        return (old & ~be_mask(be)) | (wdata & be_mask(be));
    endfunction

endpackage

// File: rtl/pwm_multi_avalon_channel.sv
// One PWM channel: active period/duty reload at the period boundary, counter, raw level.
module pwm_channel #(
    parameter int unsigned      CNT_W          = 32,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = '0,
    parameter logic [CNT_W-1:0] DEFAULT_DUTY   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] per_s,
    input  logic [CNT_W-1:0] duty_s,
    output logic             raw,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_a_q, per_a_d;
    logic [CNT_W-1:0] duty_a_q, duty_a_d;
    logic             running;

    // A zero period parks the channel exactly like a disabled one.
    assign running = enable && (per_a_q != '0);
    assign wrap    = running && (cnt_q == per_a_q - CNT_W'(1));
    assign raw     = running && (cnt_q < duty_a_q);

    always_comb begin
        cnt_d    = cnt_q + CNT_W'(1);
        per_a_d  = per_a_q;
        duty_a_d = duty_a_q;
        if (!running || wrap) begin
            cnt_d    = '0;
            per_a_d  = per_s;
            duty_a_d = duty_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            per_a_q  <= DEFAULT_PERIOD;
            duty_a_q <= DEFAULT_DUTY;
        end else begin
            cnt_q    <= cnt_d;
            per_a_q  <= per_a_d;
            duty_a_q <= duty_a_d;
        end
    end

endmodule

// File: rtl/pwm_multi_avalon.sv
// Multi-channel PWM behind an Avalon-MM slave: register file, decode, status/IRQ, polarity.
module pwm_multi_avalon
    import pwm_multi_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned DEFAULT_PERIOD = 500000,
    parameter int unsigned DEFAULT_DUTY   = 250000
) (
    input  logic                      csi_clk,
    input  logic                      rsi_rst_n,
    input  logic                      avs_s0_chipselect,
    input  logic                      avs_s0_read,
    input  logic                      avs_s0_write,
    input  logic [addr_w(NUM_CH)-1:0] avs_s0_address,
    input  logic [3:0]                avs_s0_byteenable,
    input  logic [31:0]               avs_s0_writedata,
    output logic [31:0]               avs_s0_readdata,
    output logic                      ins_irq,
    output logic [NUM_CH-1:0]         coe_pwm_out
);

    localparam logic [CNT_W-1:0] DEF_PER  = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] DEF_DUTY = CNT_W'(DEFAULT_DUTY);

    logic [NUM_CH-1:0] ctrl_q, ctrl_d, pol_q, pol_d, status_q, status_d, irq_en_q, irq_en_d;
    logic [NUM_CH-1:0] status_clr, raw, wrap, pwm_q;
    logic [CNT_W-1:0]  per_s_q [NUM_CH];
    logic [CNT_W-1:0]  per_s_d [NUM_CH];
    logic [CNT_W-1:0]  duty_s_q [NUM_CH];
    logic [CNT_W-1:0]  duty_s_d [NUM_CH];
    logic [31:0]       readdata_q, rdata, addr;
    logic              wr, rd;

    assign wr   = avs_s0_chipselect && avs_s0_write;
    assign rd   = avs_s0_chipselect && avs_s0_read;
    assign addr = 32'(avs_s0_address);

    always_comb begin
        ctrl_d     = ctrl_q;
        pol_d      = pol_q;
        irq_en_d   = irq_en_q;
        status_clr = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            per_s_d[i]  = per_s_q[i];
            duty_s_d[i] = duty_s_q[i];
        end
        if (wr) begin
            case (addr)
                REG_CTRL:   ctrl_d   = NUM_CH'(merge(32'(ctrl_q), avs_s0_writedata,
                                                     avs_s0_byteenable));
                REG_POL:    pol_d    = NUM_CH'(merge(32'(pol_q), avs_s0_writedata,
                                                     avs_s0_byteenable));
                REG_STATUS: status_clr = NUM_CH'(avs_s0_writedata & be_mask(avs_s0_byteenable));
                REG_IRQ_EN: irq_en_d = NUM_CH'(merge(32'(irq_en_q), avs_s0_writedata,
                                                     avs_s0_byteenable));
                default: begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (addr == CH_BASE + CH_STRIDE * i) begin
                            per_s_d[i] = CNT_W'(merge(32'(per_s_q[i]), avs_s0_writedata,
                                                      avs_s0_byteenable));
                        end
                        if (addr == CH_BASE + CH_STRIDE * i + 1) begin
                            duty_s_d[i] = CNT_W'(merge(32'(duty_s_q[i]), avs_s0_writedata,
                                                       avs_s0_byteenable));
                        end
                    end
                end
            endcase
        end
        // A wrap in the same cycle as a clear keeps the flag set.
        status_d = (status_q & ~status_clr) | wrap;
    end

    always_comb begin
        rdata = '0;
        case (addr)
            REG_CTRL:   rdata = 32'(ctrl_q);
            REG_POL:    rdata = 32'(pol_q);
            REG_STATUS: rdata = 32'(status_q);
            REG_IRQ_EN: rdata = 32'(irq_en_q);
            default: begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (addr == CH_BASE + CH_STRIDE * i)     rdata = 32'(per_s_q[i]);
                    if (addr == CH_BASE + CH_STRIDE * i + 1) rdata = 32'(duty_s_q[i]);
                end
            end
        endcase
    end

    always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
        if (!rsi_rst_n) begin
            ctrl_q     <= '0;
            pol_q      <= '0;
            status_q   <= '0;
            irq_en_q   <= '0;
            pwm_q      <= '0;
            readdata_q <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                per_s_q[i]  <= DEF_PER;
                duty_s_q[i] <= DEF_DUTY;
            end
        end else begin
            ctrl_q   <= ctrl_d;
            pol_q    <= pol_d;
            status_q <= status_d;
            irq_en_q <= irq_en_d;
            pwm_q    <= raw;
            if (rd) readdata_q <= rdata;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                per_s_q[i]  <= per_s_d[i];
                duty_s_q[i] <= duty_s_d[i];
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel #(
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (DEF_PER),
            .DEFAULT_DUTY   (DEF_DUTY)
        ) u_ch (
            .clk    (csi_clk),
            .rst_n  (rsi_rst_n),
            .enable (ctrl_q[i]),
            .per_s  (per_s_q[i]),
            .duty_s (duty_s_q[i]),
            .raw    (raw[i]),
            .wrap   (wrap[i])
        );
    end

    assign avs_s0_readdata = readdata_q;
    assign coe_pwm_out     = pwm_q ^ pol_q;
    assign ins_irq         = |(status_q & irq_en_q);

endmodule

// File: tb/tb_pwm_multi_avalon.sv
// Directed bench for pwm_multi_avalon with NUM_CH=4, CNT_W=32.
module tb_pwm_multi_avalon;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [3:0]  addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;
    logic [3:0]  pwm;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_multi_avalon #(
        .NUM_CH         (4),
        .CNT_W          (32),
        .DEFAULT_PERIOD (500000),
        .DEFAULT_DUTY   (250000)
    ) dut (
        .csi_clk           (clk),
        .rsi_rst_n         (rst_n),
        .avs_s0_chipselect (cs),
        .avs_s0_read       (rd),
        .avs_s0_write      (wr),
        .avs_s0_address    (addr),
        .avs_s0_byteenable (be),
        .avs_s0_writedata  (wdata),
        .avs_s0_readdata   (rdata),
        .ins_irq           (irq),
        .coe_pwm_out       (pwm)
    );

    // Called at a negedge; the write lands on the following posedge, returns at the next negedge.
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d; be = b;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; be = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        d = rdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        @(negedge clk);
        checks++;
        if (pwm !== 4'h0 || irq !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs pwm=%h irq=%b rdata=%h want 0/0/0", pwm, irq, rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(4'd4, v);
        checks++;
        if (v !== 32'd500000) begin
            errors++; $display("FAIL reset_period0 got %0d want 500000", v);
        end
        bus_read(4'd11, v);
        checks++;
        if (v !== 32'd250000) begin
            errors++; $display("FAIL reset_duty3 got %0d want 250000", v);
        end
        bus_read(4'd0, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL reset_ctrl got %h want 0", v);
        end
        bus_read(4'd13, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL unmapped_read got %h want 0", v);
        end
    endtask

    task automatic test_pwm_basic();
        logic exp;
        bus_write(4'd4, 32'd10, 4'hF);
        bus_write(4'd5, 32'd3, 4'hF);
        bus_write(4'd0, 32'h1, 4'hF);
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) @(negedge clk);
            exp = (k == 0) ? 1'b0 : (((k - 1) % 10) < 3);
            checks++;
            if (pwm !== {3'b000, exp}) begin
                errors++; $display("FAIL basic_k%0d pwm=%b want %b", k, pwm, {3'b000, exp});
            end
        end
    endtask

    task automatic test_duty_change();
        logic exp;
        bus_write(4'd0, 32'h0, 4'hF);
        @(negedge clk);
        bus_write(4'd0, 32'h1, 4'hF);
        for (int k = 0; k <= 30; k++) begin
            if (k == 6) bus_write(4'd5, 32'd7, 4'hF);
            else if (k > 0) @(negedge clk);
            if (k == 0) exp = 1'b0;
            else if (k <= 10) exp = ((k - 1) % 10) < 3;
            else exp = ((k - 1) % 10) < 7;
            checks++;
            if (pwm[0] !== exp) begin
                errors++; $display("FAIL duty_change_k%0d pwm0=%b want %b", k, pwm[0], exp);
            end
        end
    endtask

    task automatic test_byteenable();
        logic [31:0] v;
        bus_write(4'd6, 32'hAABBCCDD, 4'b0010);
        bus_read(4'd6, v);
        checks++;
        if (v !== 32'h0007CC20) begin
            errors++; $display("FAIL be_period1 got %h want 0007cc20", v);
        end
        bus_write(4'd3, 32'hFFFFFFFF, 4'hF);
        bus_read(4'd3, v);
        checks++;
        if (v !== 32'h0000000F) begin
            errors++; $display("FAIL irq_en_width got %h want 0000000f", v);
        end
        bus_write(4'd3, 32'h0, 4'hF);
    endtask

    task automatic test_irq();
        logic [31:0] v;
        bus_write(4'd0, 32'h0, 4'hF);
        bus_write(4'd2, 32'hF, 4'hF);
        bus_write(4'd3, 32'h1, 4'hF);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_idle got %b want 0", irq);
        end
        bus_write(4'd0, 32'h1, 4'hF);
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (irq !== (k == 10)) begin
                errors++; $display("FAIL irq_rise_k%0d got %b want %b", k, irq, k == 10);
            end
        end
        bus_read(4'd2, v);
        checks++;
        if (v !== 32'h1) begin
            errors++; $display("FAIL status_set got %h want 1", v);
        end
        bus_write(4'd2, 32'h1, 4'hF);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL w1c_clear got %b want 0", irq);
        end
        repeat (7) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_before_wrap got %b want 0", irq);
        end
        bus_write(4'd2, 32'h1, 4'hF);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL set_beats_clear got %b want 1", irq);
        end
        bus_write(4'd2, 32'h1, 4'b0010);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL w1c_lane_gated got %b want 1", irq);
        end
        bus_write(4'd2, 32'h1, 4'b0001);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL w1c_lane0 got %b want 0", irq);
        end
    endtask

    task automatic test_polarity();
        logic [31:0] v;
        bus_write(4'd0, 32'h0, 4'hF);
        bus_write(4'd3, 32'h0, 4'hF);
        @(negedge clk);
        bus_write(4'd1, 32'h2, 4'hF);
        checks++;
        if (pwm !== 4'b0010) begin
            errors++; $display("FAIL pol_idle got %b want 0010", pwm);
        end
        bus_write(4'd6, 32'd20, 4'hF);
        bus_write(4'd7, 32'd20, 4'hF);
        bus_write(4'd0, 32'h2, 4'hF);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            checks++;
            if (pwm[1] !== 1'b0) begin
                errors++; $display("FAIL full_duty_k%0d got %b want 0", k, pwm[1]);
            end
        end
        bus_write(4'd6, 32'd0, 4'hF);
        repeat (25) @(negedge clk);
        bus_write(4'd2, 32'hF, 4'hF);
        bus_write(4'd3, 32'h2, 4'hF);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            checks++;
            if (pwm[1] !== 1'b1 || irq !== 1'b0) begin
                errors++;
                $display("FAIL zero_period_k%0d pwm1=%b irq=%b want 1/0", k, pwm[1], irq);
            end
        end
        bus_read(4'd2, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL zero_period_status got %h want 0", v);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        bus_write(4'd1, 32'h5, 4'hF);
        bus_write(4'd0, 32'h1, 4'hF);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pwm !== 4'h0 || irq !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid pwm=%b irq=%b rdata=%h want 0/0/0", pwm, irq, rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(4'd4, v);
        checks++;
        if (v !== 32'd500000) begin
            errors++; $display("FAIL reset_mid_period0 got %0d want 500000", v);
        end
    endtask

    initial begin
        test_reset();
        test_pwm_basic();
        test_duty_change();
        test_byteenable();
        test_irq();
        test_polarity();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
